pipeline_hazard_ctrl: RTL and testbench
=======================================

PIPELINE_HAZARD_CTRL -- requirements
Module: pipeline_hazard_ctrl

Interface
REQ-001 Parameter REG_W, default 5, register-address width.
REQ-002 Parameter DEPTH, default 3, number of shadow stages tracked past ID (EX=0, MEM=1, WB=2).
REQ-003 Parameter LOAD_STAGE, default 1, shadow index at whose end load data becomes forwardable; legal range 0..DEPTH-1.
REQ-004 Parameter MDU_LAT, default 32, mult/div busy cycles, minimum 1.
REQ-005 Parameter CNT_W, default 32, stall-counter width.
REQ-006 clk  in  1  sole clock, rising edge.
REQ-007 rst  in  1  asynchronous, active-high reset.
REQ-008 id_valid  in  1  ID holds a real instruction.
REQ-009 id_rs, id_rt  in  REG_W each  ID source addresses.
REQ-010 id_use_rs, id_use_rt  in  1 each  source consumed by ALU/memory in EX.
REQ-011 id_cmp_rs, id_cmp_rt  in  1 each  source consumed in ID (branch compare, jr).
REQ-012 id_dest  in  REG_W  ID destination; id_reg_write  in  1; id_is_load  in  1.
REQ-013 id_redirect  in  1  unconditional redirect in ID (j, eret); branch_taken  in  1.
REQ-014 id_mdu_start, id_hilo_read  in  1 each  mult/div issue; mfhi/mflo.
REQ-015 mem_stall  in  1  memory not ready, whole pipeline frozen.
REQ-016 inta  in  1  interrupt acknowledge, held by requester until accepted.
REQ-017 pc_write, if_id_write, if_id_flush, id_ex_flush  out  1 each  pipeline controls.
REQ-018 mdu_busy  out  1  MDU counter nonzero; stall_cnt  out  CNT_W  data-hazard stall cycles.

Function
REQ-019 Shadow entry = {valid, dest, is_load}; dest 0 or reg_write=0 never creates an entry.
REQ-020 ALU hazard: valid load entry at index k < LOAD_STAGE, dest matching a used (id_use_*) source.
REQ-021 ID hazard: matching id_cmp_* source against any valid entry at index 0, or a load entry at index k <= LOAD_STAGE.
REQ-022 MDU hazard: mdu_busy=1 and (id_mdu_start or id_hilo_read).
REQ-023 Hazards are evaluated only when id_valid=1.
REQ-024 Priority, highest first: rst; mem_stall; inta; hazard; redirect; normal.
REQ-025 mem_stall: pc_write=0, if_id_write=0, flushes=0; shadow, MDU counter and stall_cnt hold; inta ignored.
REQ-026 inta: pc_write=1, if_id_write=1, if_id_flush=1, id_ex_flush=1.
REQ-027 Hazard: pc_write=0, if_id_write=0, if_id_flush=0, id_ex_flush=1.
REQ-028 Redirect (id_redirect, or branch_taken with id_cmp_rs): pc_write=1, if_id_write=1, if_id_flush=1, id_ex_flush=0.
REQ-029 Normal: pc_write=1, if_id_write=1, flushes=0.
REQ-030 Non-frozen edge: entries shift one index, last discarded; index 0 loads the ID entry if issued (no inta/hazard), else a bubble.
REQ-031 Shadow entries already at index 0 and beyond are never flushed by inta.
REQ-032 MDU counter loads MDU_LAT when id_mdu_start issues, else decrements toward 0 on non-frozen edges; continues through inta.
REQ-033 stall_cnt increments on each non-frozen hazard cycle, saturating at all-ones.
REQ-034 Outputs are combinational from inputs and state; zero-cycle latency.

Reset
REQ-035 rst clears all shadow valid bits, MDU counter and stall_cnt immediately.
REQ-036 While rst=1: pc_write=0, if_id_write=0, if_id_flush=1, id_ex_flush=1, mdu_busy=0.
REQ-037 rst asserted mid-stall or mid-MDU abandons that operation; first post-reset cycle is normal.

Structure
REQ-038 Shared package mips_hazard_pkg holds the shadow-entry typedef and the REG_W default.
REQ-039 Shadow shift register is one sub-module, hazard_shadow_pipe, parametrised by DEPTH and REG_W.

Verification
REQ-040 Load-use: lw to r5, then add reading r5 -> one-cycle hazard outputs (0,0,0,1), stall_cnt=1, then normal.
REQ-041 Branch: add r3 in EX, beq on r3 in ID -> one stall; lw r3 instead -> two stalls; branch_taken then -> (1,1,1,0).
REQ-042 MDU: MDU_LAT=4, mult issued, mflo next -> stalls four cycles, mdu_busy falls, then issues.
REQ-043 Freeze: mem_stall=1 during load-use hazard and inta -> outputs (0,0,0,0), stall_cnt unchanged; release -> inta served first.
REQ-044 Zero register: lw r0 then add reading r0 -> no stall.
REQ-045 Reset mid-MDU: rst at busy count 2 -> mdu_busy=0, stall_cnt=0, controls per REQ-036.

Source files
------------

// File: rtl/mips_hazard_pkg.sv
// rtl/mips_hazard_pkg.sv - shared types and helpers for the pipeline hazard controller
package mips_hazard_pkg;

  // Default register-address width (32 architectural registers).
  localparam int REG_W_DEFAULT = 5;

  // Shadow entries carry destinations at this fixed width so one packed type
  // serves every instance; narrower REG_W values are zero-extended into it.
  localparam int REG_W_MAX = 8;

  // One in-flight instruction tracked past ID.
  typedef struct packed {
    logic                 valid;
    logic [REG_W_MAX-1:0] dest;
    logic                 is_load;
  } shadow_entry_t;

  localparam shadow_entry_t SHADOW_BUBBLE = '0;

  // Winning pipeline action for the current cycle, highest priority first.
  typedef enum logic [2:0] {
    ACT_RESET    = 3'd0,
    ACT_FREEZE   = 3'd1,
    ACT_INTA     = 3'd2,
    ACT_HAZARD   = 3'd3,
    ACT_REDIRECT = 3'd4,
    ACT_NORMAL   = 3'd5
  } action_e;

  // True when a consumed source register is produced by a live shadow entry.
  function automatic logic entry_hits(input shadow_entry_t e,
                                      input logic [REG_W_MAX-1:0] src,
                                      input logic used);
    return used && e.valid && (e.dest == src);
  endfunction

endpackage

// File: rtl/hazard_shadow_pipe.sv
// rtl/hazard_shadow_pipe.sv - shift register mirroring destinations of instructions past ID
module hazard_shadow_pipe
  import mips_hazard_pkg::*;
#(
  parameter int DEPTH = 3,
  parameter int REG_W = REG_W_DEFAULT
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      advance,
  input  shadow_entry_t             entry_in,
  output shadow_entry_t [DEPTH-1:0] entries
);

  shadow_entry_t [DEPTH-1:0] entries_q;
  shadow_entry_t [DEPTH-1:0] entries_d;
  logic [REG_W_MAX-1:0]      dest_mask;

  // Only the low REG_W destination bits are meaningful for this instance.
  always_comb begin
    dest_mask              = '0;
    dest_mask[REG_W-1:0]   = '1;
  end

  // Shift one stage per advancing cycle; the oldest entry falls off the end.
  always_comb begin
    entries_d = entries_q;
    if (advance) begin
      for (int k = DEPTH - 1; k > 0; k--) begin
        entries_d[k] = entries_q[k-1];
      end
      entries_d[0]      = entry_in;
      entries_d[0].dest = entry_in.dest & dest_mask;
    end
  end

  // Shadow state register; reset empties every stage.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      entries_q <= '0;
    end else begin
      entries_q <= entries_d;
    end
  end

  assign entries = entries_q;

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// rtl/pipeline_hazard_ctrl.sv - stall, flush and interrupt control for a 5-stage MIPS pipeline
module pipeline_hazard_ctrl
  import mips_hazard_pkg::*;
#(
  parameter int REG_W      = REG_W_DEFAULT,
  parameter int DEPTH      = 3,
  parameter int LOAD_STAGE = 1,
  parameter int MDU_LAT    = 32,
  parameter int CNT_W      = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_valid,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             id_use_rs,
  input  logic             id_use_rt,
  input  logic             id_cmp_rs,
  input  logic             id_cmp_rt,
  input  logic [REG_W-1:0] id_dest,
  input  logic             id_reg_write,
  input  logic             id_is_load,
  input  logic             id_redirect,
  input  logic             branch_taken,
  input  logic             id_mdu_start,
  input  logic             id_hilo_read,
  input  logic             mem_stall,
  input  logic             inta,
  output logic             pc_write,
  output logic             if_id_write,
  output logic             if_id_flush,
  output logic             id_ex_flush,
  output logic             mdu_busy,
  output logic [CNT_W-1:0] stall_cnt
);

  localparam int MDU_W = $clog2(MDU_LAT + 1);

  shadow_entry_t [DEPTH-1:0] entries;
  shadow_entry_t             entry_in;
  logic [REG_W_MAX-1:0]      rs_x;
  logic [REG_W_MAX-1:0]      rt_x;
  logic [REG_W_MAX-1:0]      dest_x;
  logic                      alu_hz;
  logic                      id_hz;
  logic                      mdu_hz;
  logic                      hazard;
  logic                      redirect;
  logic                      mdu_nonzero;
  logic                      advance;
  logic                      issue;
  action_e                   action;
  logic [MDU_W-1:0]          mdu_cnt_q;
  logic [MDU_W-1:0]          mdu_cnt_d;
  logic [CNT_W-1:0]          stall_cnt_q;
  logic [CNT_W-1:0]          stall_cnt_d;

  // Widen ID register fields to the shadow-entry destination width.
  always_comb begin
    rs_x               = '0;
    rt_x               = '0;
    dest_x             = '0;
    rs_x[REG_W-1:0]    = id_rs;
    rt_x[REG_W-1:0]    = id_rt;
    dest_x[REG_W-1:0]  = id_dest;
  end

  // Compare ID sources against in-flight destinations. Loads are only
  // forwardable once they pass LOAD_STAGE; branch compares in ID also need
  // the EX result, which is not yet available to them.
  always_comb begin
    alu_hz = 1'b0;
    id_hz  = 1'b0;
    for (int k = 0; k < DEPTH; k++) begin
      if ((k < LOAD_STAGE) && entries[k].is_load &&
          (entry_hits(entries[k], rs_x, id_use_rs) ||
           entry_hits(entries[k], rt_x, id_use_rt))) begin
        alu_hz = 1'b1;
      end
      if (((k == 0) || ((k <= LOAD_STAGE) && entries[k].is_load)) &&
          (entry_hits(entries[k], rs_x, id_cmp_rs) ||
           entry_hits(entries[k], rt_x, id_cmp_rt))) begin
        id_hz = 1'b1;
      end
    end
  end

  // MDU structural hazard and overall hazard / redirect qualification.
  always_comb begin
    mdu_nonzero = (mdu_cnt_q != '0);
    mdu_hz      = mdu_nonzero && (id_mdu_start || id_hilo_read);
    hazard      = id_valid && (alu_hz || id_hz || mdu_hz);
    redirect    = id_redirect || (branch_taken && id_cmp_rs);
  end

  // Pick the single winning action by fixed priority.
  always_comb begin
    action = ACT_NORMAL;
    if (rst) begin
      action = ACT_RESET;
    end else if (mem_stall) begin
      action = ACT_FREEZE;
    end else if (inta) begin
      action = ACT_INTA;
    end else if (hazard) begin
      action = ACT_HAZARD;
    end else if (redirect) begin
      action = ACT_REDIRECT;
    end
  end

  // Drive pipeline controls from the winning action.
  always_comb begin
    pc_write    = 1'b1;
    if_id_write = 1'b1;
    if_id_flush = 1'b0;
    id_ex_flush = 1'b0;
    case (action)
      ACT_RESET: begin
        pc_write    = 1'b0;
        if_id_write = 1'b0;
        if_id_flush = 1'b1;
        id_ex_flush = 1'b1;
      end
      ACT_FREEZE: begin
        pc_write    = 1'b0;
        if_id_write = 1'b0;
      end
      ACT_INTA: begin
        if_id_flush = 1'b1;
        id_ex_flush = 1'b1;
      end
      ACT_HAZARD: begin
        pc_write    = 1'b0;
        if_id_write = 1'b0;
        id_ex_flush = 1'b1;
      end
      ACT_REDIRECT: begin
        if_id_flush = 1'b1;
      end
      default: begin
      end
    endcase
    mdu_busy  = mdu_nonzero && !rst;
    stall_cnt = stall_cnt_q;
  end

  // The ID instruction enters the shadow only when it actually moves to EX;
  // interrupt-flushed or stalled instructions leave a bubble behind.
  always_comb begin
    advance  = (action != ACT_RESET) && (action != ACT_FREEZE);
    issue    = (action == ACT_REDIRECT) || (action == ACT_NORMAL);
    entry_in = SHADOW_BUBBLE;
    if (issue && id_valid && id_reg_write && (id_dest != '0)) begin
      entry_in.valid   = 1'b1;
      entry_in.dest    = dest_x;
      entry_in.is_load = id_is_load;
    end
  end

  // MDU busy counter and saturating data-hazard stall counter.
  always_comb begin
    mdu_cnt_d   = mdu_cnt_q;
    stall_cnt_d = stall_cnt_q;
    if (advance) begin
      if (issue && id_valid && id_mdu_start) begin
        mdu_cnt_d = MDU_W'(MDU_LAT);
      end else if (mdu_nonzero) begin
        mdu_cnt_d = mdu_cnt_q - 1'b1;
      end
    end
    if ((action == ACT_HAZARD) && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + 1'b1;
    end
  end

  // Counter state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mdu_cnt_q   <= '0;
      stall_cnt_q <= '0;
    end else begin
      mdu_cnt_q   <= mdu_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  hazard_shadow_pipe #(
    .DEPTH (DEPTH),
    .REG_W (REG_W)
  ) u_shadow (
    .clk      (clk),
    .rst      (rst),
    .advance  (advance),
    .entry_in (entry_in),
    .entries  (entries)
  );

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb/tb_pipeline_hazard_ctrl.sv - scoreboard bench for the pipeline hazard controller
module tb_pipeline_hazard_ctrl;

  localparam logic [3:0] C_NORM = 4'b1100;
  localparam logic [3:0] C_HAZ  = 4'b0001;
  localparam logic [3:0] C_RED  = 4'b1110;
  localparam logic [3:0] C_INTA = 4'b1111;
  localparam logic [3:0] C_FRZ  = 4'b0000;
  localparam logic [3:0] C_RST  = 4'b0011;

  typedef struct {
    string       name;
    logic [3:0]  ctl;
    logic        busy;
    logic [31:0] cnt;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        id_valid;
  logic [4:0]  id_rs, id_rt, id_dest;
  logic        id_use_rs, id_use_rt, id_cmp_rs, id_cmp_rt;
  logic        id_reg_write, id_is_load, id_redirect, branch_taken;
  logic        id_mdu_start, id_hilo_read, mem_stall, inta;
  logic        pc_write, if_id_write, if_id_flush, id_ex_flush, mdu_busy;
  logic [31:0] stall_cnt;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  pipeline_hazard_ctrl #(.MDU_LAT(4)) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .id_cmp_rs(id_cmp_rs),
    .id_cmp_rt(id_cmp_rt), .id_dest(id_dest), .id_reg_write(id_reg_write),
    .id_is_load(id_is_load), .id_redirect(id_redirect), .branch_taken(branch_taken),
    .id_mdu_start(id_mdu_start), .id_hilo_read(id_hilo_read), .mem_stall(mem_stall),
    .inta(inta), .pc_write(pc_write), .if_id_write(if_id_write),
    .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush), .mdu_busy(mdu_busy),
    .stall_cnt(stall_cnt)
  );

  // Monitor: outputs are compared mid-cycle against the queued expectation.
  always @(negedge clk) begin
    if (sb.size() != 0) begin
      exp_t e;
      e = sb.pop_front();
      checks++;
      if ({pc_write, if_id_write, if_id_flush, id_ex_flush} !== e.ctl) begin
        errors++;
        $display("FAIL %s ctl: got %b expected %b", e.name,
                 {pc_write, if_id_write, if_id_flush, id_ex_flush}, e.ctl);
      end
      checks++;
      if (mdu_busy !== e.busy) begin
        errors++;
        $display("FAIL %s mdu_busy: got %b expected %b", e.name, mdu_busy, e.busy);
      end
      checks++;
      if (stall_cnt !== e.cnt) begin
        errors++;
        $display("FAIL %s stall_cnt: got %0d expected %0d", e.name, stall_cnt, e.cnt);
      end
    end
  end

  task automatic clr();
    id_valid = 0; id_rs = 0; id_rt = 0; id_dest = 0;
    id_use_rs = 0; id_use_rt = 0; id_cmp_rs = 0; id_cmp_rt = 0;
    id_reg_write = 0; id_is_load = 0; id_redirect = 0; branch_taken = 0;
    id_mdu_start = 0; id_hilo_read = 0; mem_stall = 0; inta = 0;
  endtask

  // ALU-style instruction: rd = rs op rt, optionally a load.
  task automatic alu(input logic [4:0] rs, input logic [4:0] rt,
                     input logic [4:0] rd, input logic ld);
    clr();
    id_valid = 1; id_rs = rs; id_rt = rt; id_use_rs = 1; id_use_rt = !ld;
    id_dest = rd; id_reg_write = 1; id_is_load = ld;
  endtask

  // Branch comparing rs and rt in ID.
  task automatic beq(input logic [4:0] rs, input logic [4:0] rt, input logic taken);
    clr();
    id_valid = 1; id_rs = rs; id_rt = rt; id_cmp_rs = 1; id_cmp_rt = 1;
    branch_taken = taken;
  endtask

  // Push the expectation for the cycle just driven, then advance one clock.
  task automatic step(input string name, input logic [3:0] ctl,
                      input logic busy, input logic [31:0] cnt);
    exp_t e;
    e.name = name; e.ctl = ctl; e.busy = busy; e.cnt = cnt;
    sb.push_back(e);
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, expected completion");
    $fatal(1);
  end

  initial begin
    clr();
    rst = 1;
    @(posedge clk); #1;
    step("reset", C_RST, 0, 0);
    rst = 0;

    // Load-use
    alu(5'd1, 5'd0, 5'd5, 1);  step("lu_lw",    C_NORM, 0, 0);
    alu(5'd5, 5'd7, 5'd6, 0);  step("lu_stall", C_HAZ,  0, 0);
    alu(5'd5, 5'd7, 5'd6, 0);  step("lu_issue", C_NORM, 0, 1);
    clr();                     step("lu_idle0", C_NORM, 0, 1);
    clr();                     step("lu_idle1", C_NORM, 0, 1);
    clr();                     step("lu_idle2", C_NORM, 0, 1);

    // Branch after ALU producer, then after load producer
    alu(5'd1, 5'd2, 5'd3, 0);  step("br_add",    C_NORM, 0, 1);
    beq(5'd3, 5'd0, 0);        step("br_stall",  C_HAZ,  0, 1);
    beq(5'd3, 5'd0, 1);        step("br_taken",  C_RED,  0, 2);
    clr();                     step("br_idle0",  C_NORM, 0, 2);
    clr();                     step("br_idle1",  C_NORM, 0, 2);
    alu(5'd1, 5'd0, 5'd3, 1);  step("brl_lw",    C_NORM, 0, 2);
    beq(5'd3, 5'd0, 0);        step("brl_st1",   C_HAZ,  0, 2);
    beq(5'd3, 5'd0, 0);        step("brl_st2",   C_HAZ,  0, 3);
    beq(5'd3, 5'd0, 1);        step("brl_taken", C_RED,  0, 4);
    clr();                     step("brl_idle0", C_NORM, 0, 4);
    clr();                     step("brl_idle1", C_NORM, 0, 4);

    // Zero register never stalls
    alu(5'd1, 5'd0, 5'd0, 1);  step("r0_lw",  C_NORM, 0, 4);
    alu(5'd0, 5'd0, 5'd6, 0);  step("r0_add", C_NORM, 0, 4);
    clr();                     step("r0_idle", C_NORM, 0, 4);

    // Freeze over a load-use hazard with a pending interrupt
    alu(5'd1, 5'd0, 5'd5, 1);  step("fz_lw", C_NORM, 0, 4);
    alu(5'd5, 5'd7, 5'd6, 0); mem_stall = 1; inta = 1;
    step("fz_frozen0", C_FRZ, 0, 4);
    alu(5'd5, 5'd7, 5'd6, 0); mem_stall = 1; inta = 1;
    step("fz_frozen1", C_FRZ, 0, 4);
    alu(5'd5, 5'd7, 5'd6, 0); inta = 1;
    step("fz_inta", C_INTA, 0, 4);
    clr();                     step("fz_after", C_NORM, 0, 4);
    clr();                     step("fz_idle0", C_NORM, 0, 4);
    clr();                     step("fz_idle1", C_NORM, 0, 4);

    // MDU busy: mult then mflo
    clr(); id_valid = 1; id_mdu_start = 1;
    step("mdu_mult", C_NORM, 0, 4);
    for (int i = 0; i < 4; i++) begin
      clr(); id_valid = 1; id_hilo_read = 1; id_dest = 5'd8; id_reg_write = 1;
      step("mdu_stall", C_HAZ, 1, 32'(4 + i));
    end
    clr(); id_valid = 1; id_hilo_read = 1; id_dest = 5'd8; id_reg_write = 1;
    step("mdu_issue", C_NORM, 0, 8);
    clr();                     step("mdu_idle", C_NORM, 0, 8);

    // Reset in the middle of an MDU operation
    clr(); id_valid = 1; id_mdu_start = 1;
    step("rm_mult", C_NORM, 0, 8);
    clr();                     step("rm_busy4", C_NORM, 1, 8);
    clr();                     step("rm_busy3", C_NORM, 1, 8);
    clr(); rst = 1;            step("rm_reset", C_RST,  0, 0);
    rst = 0;
    clr(); id_valid = 1; id_hilo_read = 1; id_dest = 5'd8; id_reg_write = 1;
    step("rm_post", C_NORM, 0, 0);

    @(negedge clk); #1;
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
